// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read-side streaming blocks.
//   DEFAULT_DATA_WIDTH : default FIFO word / stream data width
//   DEFAULT_CNT_WIDTH  : default width of the delivered-word counter
//   occ_t              : skid buffer occupancy (EMPTY, ONE, TWO)
//   beat_t             : one stream beat at the default data width
//   occ_fill()         : buffer fill level after this edge, counting the
//                        word in flight from the FIFO and the word leaving
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } beat_t;

    // Buffered words plus the word landing this edge, minus the word popped
    // this edge. A pop only happens with occ >= 1, so this never goes
    // negative; the extra bit keeps the sum from wrapping.
    function automatic logic [2:0] occ_fill(occ_t occ, logic pend, logic pop);
        return {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_skid_buf2.sv
// ----------------------------------------------------------------------------
// fifo_skid_buf2
// Two-entry skid buffer that absorbs the FIFO's one-cycle read latency.
// Entry 0 is always the head of the stream and drives the output directly,
// so the output data is registered.
//
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset, empties the buffer
//   push       : write push_data into the tail this edge
//   push_data  : word to write
//   pop        : head word is consumed this edge
//   occ        : current occupancy (EMPTY / ONE / TWO)
//   head       : entry 0, the word presented downstream
// ----------------------------------------------------------------------------
module fifo_skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head
);

    occ_t                  occ_q;
    occ_t                  occ_d;
    logic [DATA_WIDTH-1:0] entry0_q;
    logic [DATA_WIDTH-1:0] entry1_q;
    logic [DATA_WIDTH-1:0] entry0_d;
    logic [DATA_WIDTH-1:0] entry1_d;

    // Occupancy and both entries are registered together. Reset empties the
    // buffer and zeroes the data so the output word reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= OCC_EMPTY;
            entry0_q <= '0;
            entry1_q <= '0;
        end else begin
            occ_q    <= occ_d;
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
        end
    end

    // Next-state logic. The tail is entry 0 when the buffer is empty or when
    // the only buffered word is leaving; otherwise it is entry 1. Popping a
    // full buffer shifts entry 1 forward so the head stays in entry 0.
    // A push into a full buffer without a pop cannot happen because the
    // read-issue logic upstream never lets occupancy plus in-flight exceed 2.
    always_comb begin
        occ_d    = occ_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    entry0_d = push_data;
                    occ_d    = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    entry0_d = push_data;
                end else if (push) begin
                    entry1_d = push_data;
                    occ_d    = OCC_TWO;
                end else if (pop) begin
                    occ_d    = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    entry0_d = entry1_q;
                    if (push) begin
                        entry1_d = push_data;
                    end else begin
                        occ_d    = OCC_ONE;
                    end
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    assign occ  = occ_q;
    assign head = entry0_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side master for a synchronous FIFO. Issues reads on the FIFO read
// port and turns its one-cycle read latency into a valid/ready stream,
// sustaining one word per clock when the consumer is always ready. Also
// counts delivered words.
//
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   en         : drain enable, gates new FIFO reads only
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO data_out, valid the cycle after an accepted read
//   fifo_cs    : FIFO chip select (follows en)
//   fifo_rd_en : FIFO read request (combinational)
//   m_valid    : output word valid
//   m_ready    : consumer ready
//   m_data     : output word (registered)
//   busy       : a read is in flight or the buffer holds words
//   word_cnt   : number of completed output handshakes, wraps
//   cnt_clr    : synchronous clear of word_cnt, wins over a pop
// ----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    input  logic                  cnt_clr
);

    occ_t       occ;
    logic       pend_q;
    logic       pop;
    logic [2:0] fill_after;

    assign pop = m_valid && m_ready;

    // A read is only issued if the word it returns is guaranteed a slot:
    // the words buffered plus the one still in flight, less the one leaving
    // now, must leave room. Looking at pop makes m_ready feed fifo_rd_en
    // combinationally, which is what keeps a ready consumer at one word per
    // clock with no bubbles.
    assign fill_after = occ_fill(occ, pend_q, pop);
    assign fifo_rd_en = en && !fifo_empty && (fill_after < 3'd2);
    assign fifo_cs    = en;

    // pend_q marks the cycle in which FIFO data for the previous read is
    // valid. It is deliberately not gated by en, so a read that was already
    // accepted is always captured. Reset drops it, losing that word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= fifo_rd_en;
        end
    end

    fifo_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pend_q),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .head      (m_data)
    );

    assign m_valid = (occ != OCC_EMPTY);
    assign busy    = pend_q || m_valid;

    // Delivered-word counter. A clear wins over a simultaneous handshake;
    // otherwise every handshake adds one and the count wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (cnt_clr) begin
            word_cnt <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Bench for fifo_rd_stream. A behavioural synchronous FIFO feeds the DUT;
// every word written to it is also pushed onto a scoreboard queue and popped
// when the DUT completes an output handshake.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_cs;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
    logic [CW-1:0] word_cnt;
    logic          cnt_clr;

    int            checks = 0;
    int            errors = 0;
    int            delivered = 0;

    logic [DW-1:0] fifo_q[$];
    int            fifo_cnt = 0;
    logic          wr_req;
    logic [DW-1:0] wr_data;
    beat_t         exp_q[$];

    logic          prev_valid;
    logic          prev_pop;
    logic [DW-1:0] prev_data;
    beat_t         mon_exp;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_cs    (fifo_cs),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .word_cnt   (word_cnt),
        .cnt_clr    (cnt_clr)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous FIFO: registered data_out, empty flag updated
    // at the clock edge. Reading while empty is a DUT error.
    assign fifo_empty = (fifo_cnt == 0);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            checks++;
            if (fifo_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL fifo_underflow: got fifo_rd_en=1 with FIFO empty, expected 0");
            end else begin
                fifo_data <= fifo_q.pop_front();
            end
        end
        if (wr_req) fifo_q.push_back(wr_data);
        fifo_cnt <= fifo_q.size();
    end

    // Stream monitor, sampled mid-cycle once inputs are settled: scoreboard
    // compare on every handshake, hold rule while stalled, buffer overflow.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_pop   = 1'b0;
        end else begin
            checks++;
            if (dut.u_skid.occ_q == OCC_TWO && dut.pend_q && !(m_valid && m_ready)) begin
                errors++;
                $display("[TB] FAIL buffer_overflow: got push into full buffer, expected none");
            end
            if (prev_valid && !prev_pop) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    errors++;
                    $display("[TB] FAIL stream_hold: got valid=%0b data=%h, expected valid=1 data=%h",
                             m_valid, m_data, prev_data);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_extra: got word %h, expected no word", m_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (m_data !== mon_exp.data) begin
                        errors++;
                        $display("[TB] FAIL scoreboard_data: got %h, expected %h", m_data, mon_exp.data);
                    end
                end
                delivered++;
            end
            prev_valid = m_valid;
            prev_pop   = m_valid && m_ready;
            prev_data  = m_data;
        end
    end

    task automatic load_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_req  = 1'b1;
            wr_data = base + DW'(i);
            exp_q.push_back('{data: wr_data});
        end
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic wait_drained(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (!busy && fifo_cnt == 0 && !wr_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; cnt_clr = 1'b0; wr_req = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", m_data); end
        checks++; if (word_cnt !== '0) begin errors++; $display("[TB] FAIL reset_cnt: got %h expected 0", word_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en: got %0b expected 0", fifo_rd_en); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream8();
        int first_rd = -1, last_rd = -1, n_rd = 0;
        int first_v = -1, last_v = -1, n_v = 0;
        bit ok;
        load_words(8, 32'h0);
        @(negedge clk);
        en = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (fifo_rd_en) begin if (first_rd < 0) first_rd = c; last_rd = c; n_rd++; end
            if (m_valid) begin if (first_v < 0) first_v = c; last_v = c; n_v++; end
        end
        checks++; if (first_rd !== 0) begin errors++; $display("[TB] FAIL s8_first_rd: got %0d expected 0", first_rd); end
        checks++; if (n_rd !== 8 || last_rd - first_rd !== 7) begin errors++; $display("[TB] FAIL s8_rd_run: got %0d reads over %0d cycles expected 8 over 8", n_rd, last_rd - first_rd + 1); end
        checks++; if (first_v !== first_rd + 2) begin errors++; $display("[TB] FAIL s8_latency: got first valid %0d expected %0d", first_v, first_rd + 2); end
        checks++; if (n_v !== 8 || last_v - first_v !== 7) begin errors++; $display("[TB] FAIL s8_valid_run: got %0d valid over %0d cycles expected 8 over 8", n_v, last_v - first_v + 1); end
        checks++; if (word_cnt !== 16'd8) begin errors++; $display("[TB] FAIL s8_cnt: got %0d expected 8", word_cnt); end
        wait_drained(20, ok);
        checks++; if (!ok || exp_q.size() != 0) begin errors++; $display("[TB] FAIL s8_drain: got %0d words left expected 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        int n_rd = 0, d0;
        bit ok;
        en = 1'b0;
        load_words(4, 32'h0);
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0; #1;
        checks++; if (word_cnt !== '0) begin errors++; $display("[TB] FAIL stall_clr: got %0d expected 0", word_cnt); end
        d0 = delivered;
        @(negedge clk);
        m_ready = 1'b0; en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (fifo_rd_en) n_rd++;
            if (m_valid) begin
                checks++;
                if (m_data !== 32'h0) begin errors++; $display("[TB] FAIL stall_hold: got %h expected 0", m_data); end
            end
        end
        checks++; if (n_rd !== 2) begin errors++; $display("[TB] FAIL stall_reads: got %0d expected 2", n_rd); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid: got %0b expected 1", m_valid); end
        @(negedge clk);
        m_ready = 1'b1;
        wait_drained(30, ok);
        checks++; if (!ok || delivered - d0 !== 4 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL stall_release: got %0d delivered expected 4", delivered - d0); end
    endtask

    task automatic test_random();
        int written = 0, d0;
        bit ok;
        d0 = delivered;
        en = 1'b1;
        for (int cyc = 0; cyc < 3000 && (delivered - d0) < 100; cyc++) begin
            @(negedge clk);
            m_ready = ($urandom_range(0, 1) == 1);
            if (written < 100 && $urandom_range(0, 9) < 7) begin
                wr_req  = 1'b1;
                wr_data = $urandom;
                exp_q.push_back('{data: wr_data});
                written++;
            end else begin
                wr_req = 1'b0;
            end
        end
        wr_req = 1'b0; m_ready = 1'b1;
        wait_drained(20, ok);
        checks++; if (!ok || delivered - d0 !== 100 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL random_count: got %0d delivered expected 100", delivered - d0); end
    endtask

    task automatic test_en_drop();
        int n_rd = 0, d0;
        bit ok;
        en = 1'b0; m_ready = 1'b1;
        load_words(3, 32'hA0);
        d0 = delivered;
        @(negedge clk);
        en = 1'b1; #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL endrop_issue: got %0b expected 1", fifo_rd_en); end
        @(negedge clk);
        en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (fifo_rd_en) n_rd++;
        end
        checks++; if (n_rd !== 0) begin errors++; $display("[TB] FAIL endrop_reads: got %0d expected 0", n_rd); end
        checks++; if (fifo_cs !== 1'b0) begin errors++; $display("[TB] FAIL endrop_cs: got %0b expected 0", fifo_cs); end
        checks++; if (delivered - d0 !== 1) begin errors++; $display("[TB] FAIL endrop_inflight: got %0d delivered expected 1", delivered - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL endrop_busy: got %0b expected 0", busy); end
        checks++; if (fifo_q.size() != 2) begin errors++; $display("[TB] FAIL endrop_left: got %0d in FIFO expected 2", fifo_q.size()); end
        @(negedge clk);
        en = 1'b1;
        wait_drained(20, ok);
        checks++; if (!ok || delivered - d0 !== 3) begin errors++; $display("[TB] FAIL endrop_resume: got %0d delivered expected 3", delivered - d0); end
    endtask

    task automatic test_counter();
        bit ok;
        en = 1'b1; m_ready = 1'b1;
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            wr_req  = 1'b1;
            wr_data = DW'(i);
            exp_q.push_back('{data: wr_data});
        end
        @(negedge clk);
        wr_req = 1'b0;
        wait_drained(50, ok);
        checks++; if (!ok || word_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL cnt_max: got %h expected ffff", word_cnt); end
        load_words(1, 32'hBEEF);
        wait_drained(20, ok);
        checks++; if (!ok || word_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL cnt_wrap: got %h expected 0000", word_cnt); end
        load_words(2, 32'hC0);
        wait_drained(20, ok);
        checks++; if (!ok || word_cnt !== 16'd2) begin errors++; $display("[TB] FAIL cnt_two: got %0d expected 2", word_cnt); end
        m_ready = 1'b0;
        load_words(1, 32'hD0);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (m_valid) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL cnt_wait_valid: got no valid expected valid"); end
        @(negedge clk);
        m_ready = 1'b1; cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0; #1;
        checks++; if (word_cnt !== '0) begin errors++; $display("[TB] FAIL cnt_clr_pop: got %0d expected 0", word_cnt); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL cnt_clr_popped: got valid %0b expected 0", m_valid); end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit ok;
        en = 1'b0; m_ready = 1'b0;
        load_words(5, 32'h100);
        @(negedge clk);
        en = 1'b1;
        repeat (6) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1 || word_cnt !== 16'd1) begin errors++; $display("[TB] FAIL rstmid_pre: got busy=%0b cnt=%0d expected busy=1 cnt=1", busy, word_cnt); end
        rst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %0b expected 0", m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %0b expected 0", busy); end
        checks++; if (word_cnt !== '0) begin errors++; $display("[TB] FAIL rstmid_cnt: got %0d expected 0", word_cnt); end
        checks++; if (m_data !== '0) begin errors++; $display("[TB] FAIL rstmid_data: got %h expected 0", m_data); end
        checks++; if (fifo_q.size() != 2) begin errors++; $display("[TB] FAIL rstmid_fifo: got %0d in FIFO expected 2", fifo_q.size()); end
        // Buffered and in-flight words are lost; resume from FIFO contents.
        exp_q.delete();
        foreach (fifo_q[i]) exp_q.push_back('{data: fifo_q[i]});
        d0 = delivered;
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; m_ready = 1'b1;
        wait_drained(20, ok);
        checks++; if (!ok || delivered - d0 !== 2 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL rstmid_resume: got %0d delivered expected 2", delivered - d0); end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_stream8();
        test_stall();
        test_random();
        test_en_drop();
        test_counter();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
